// File: rtl/serdes_lb_pkg.sv
// serdes_lb_pkg: shared constants and FSM state type for the SERDES loopback checker
package serdes_lb_pkg;
  localparam int LANES = 8;
  localparam logic [7:0] COMMA_BYTE = 8'hBC;
  localparam logic [7:0] FILL_BYTE = 8'h4A;
  typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} lb_state_e;
endpackage

// File: rtl/serdes_lb_if.sv
// serdes_lb_if: decoded RX word bus from the SERDES into the loopback checker
interface serdes_lb_if;
  logic [63:0] rx_data_i;
  logic [7:0] rx_k_i;
  logic [7:0] rx_nit_i;
  logic [7:0] rx_disp_err_i;
  logic rx_aligned_i;
  modport master(output rx_data_i, rx_k_i, rx_nit_i, rx_disp_err_i, rx_aligned_i);
  modport slave(input rx_data_i, rx_k_i, rx_nit_i, rx_disp_err_i, rx_aligned_i);
endinterface

// File: rtl/serdes_lb_word_cmp.sv
// serdes_lb_word_cmp: classifies a 64-bit word against the one-comma/seven-fill loopback pattern
module serdes_lb_word_cmp
  import serdes_lb_pkg::*;
(
  input  logic [63:0] data,
  input  logic [7:0]  k,
  input  logic [7:0]  nit,
  input  logic [7:0]  disp_err,
  output logic        good,
  output logic [2:0]  lane
);
  always_comb begin
    lane = 3'd0;
    for (int i = 0; i < LANES; i++)
      if (k[i]) lane = i[2:0];
    good = (k == (8'd1 << lane)) && ~|nit && ~|disp_err;
    for (int i = 0; i < LANES; i++)
      good &= data[8*i +: 8] == ((3'(i) == lane) ? COMMA_BYTE : FILL_BYTE);
  end
endmodule

// File: rtl/serdes_lb_checker.sv
// serdes_lb_checker: RX loopback pattern checker with comma-lane lock FSM and error/word counters
module serdes_lb_checker
  import serdes_lb_pkg::*;
#(
  parameter int LOCK_WORDS  = 16,
  parameter int UNLOCK_ERRS = 4
)(
  input  logic        rx_clk,
  input  logic        rx_rstn_i,
  serdes_lb_if.slave  rx,
  input  logic        clr_i,
  output logic        locked_o,
  output logic [2:0]  comma_lane_o,
  output logic        err_o,
  output logic [15:0] err_cnt_o,
  output logic [31:0] word_cnt_o
);
  logic [63:0] data_q;
  logic [7:0] k_q, nit_q, disp_q;
  logic aligned_q, clr_q;
  logic good, match, err_n, word_inc;
  logic [2:0] lane, lane_n;
  logic [7:0] good_cnt, good_cnt_n;
  logic [3:0] bad_cnt, bad_cnt_n;
  lb_state_e state, state_n;
  always_ff @(posedge rx_clk or negedge rx_rstn_i)
    if (!rx_rstn_i) begin
      data_q <= '0;
      k_q <= '0;
      nit_q <= '0;
      disp_q <= '0;
      aligned_q <= 1'b0;
      clr_q <= 1'b0;
    end else begin
      data_q <= rx.rx_data_i;
      k_q <= rx.rx_k_i;
      nit_q <= rx.rx_nit_i;
      disp_q <= rx.rx_disp_err_i;
      aligned_q <= rx.rx_aligned_i;
      clr_q <= clr_i;
    end
  serdes_lb_word_cmp u_cmp (
    .data(data_q),
    .k(k_q),
    .nit(nit_q),
    .disp_err(disp_q),
    .good(good),
    .lane(lane)
  );
  assign match = good && lane == comma_lane_o;
  always_comb begin
    state_n = state;
    lane_n = comma_lane_o;
    good_cnt_n = good_cnt;
    bad_cnt_n = bad_cnt;
    err_n = 1'b0;
    word_inc = 1'b0;
    if (!aligned_q) begin
      state_n = HUNT;
      good_cnt_n = '0;
      bad_cnt_n = '0;
    end else
      case (state)
        HUNT:
          if (good) begin
            state_n = VERIFY;
            lane_n = lane;
            good_cnt_n = 8'd1;
          end
        VERIFY:
          if (!match) begin
            state_n = HUNT;
            good_cnt_n = '0;
          end else if (good_cnt == 8'(LOCK_WORDS)) begin
            state_n = LOCKED;
            bad_cnt_n = '0;
          end else
            good_cnt_n = good_cnt + 8'd1;
        LOCKED: begin
          word_inc = 1'b1;
          err_n = !match;
          bad_cnt_n = match ? 4'd0 : bad_cnt + 4'd1;
          state_n = bad_cnt_n == 4'(UNLOCK_ERRS) ? HUNT : LOCKED;
        end
        default: state_n = HUNT;
      endcase
  end
  always_ff @(posedge rx_clk or negedge rx_rstn_i)
    if (!rx_rstn_i) begin
      state <= HUNT;
      comma_lane_o <= '0;
      good_cnt <= '0;
      bad_cnt <= '0;
      err_o <= 1'b0;
      err_cnt_o <= '0;
      word_cnt_o <= '0;
    end else begin
      state <= state_n;
      comma_lane_o <= lane_n;
      good_cnt <= good_cnt_n;
      bad_cnt <= bad_cnt_n;
      err_o <= err_n;
      err_cnt_o <= clr_q ? '0 : (err_n && ~&err_cnt_o) ? err_cnt_o + 16'd1 : err_cnt_o;
      word_cnt_o <= clr_q ? '0 : (word_inc && ~&word_cnt_o) ? word_cnt_o + 32'd1 : word_cnt_o;
    end
  assign locked_o = state == LOCKED;
endmodule

// File: tb/tb_serdes_lb_checker.sv
// tb_serdes_lb_checker: directed table-driven and sequence checks of the loopback checker
module tb_serdes_lb_checker;
  import serdes_lb_pkg::*;
  typedef struct {
    logic        bad;
    logic        exp_err;
    logic [15:0] exp_cnt;
    logic        exp_lock;
  } vec_t;
  logic rx_clk = 1'b0;
  logic rx_rstn_i = 1'b0;
  logic clr_i = 1'b0;
  logic locked_o, err_o;
  logic [2:0] comma_lane_o;
  logic [15:0] err_cnt_o;
  logic [31:0] word_cnt_o;
  int n_run = 0;
  int n_fail = 0;
  vec_t tbl [14];
  serdes_lb_if rx();
  serdes_lb_checker dut (
    .rx_clk(rx_clk),
    .rx_rstn_i(rx_rstn_i),
    .rx(rx),
    .clr_i(clr_i),
    .locked_o(locked_o),
    .comma_lane_o(comma_lane_o),
    .err_o(err_o),
    .err_cnt_o(err_cnt_o),
    .word_cnt_o(word_cnt_o)
  );
  always #5 rx_clk = ~rx_clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask
  task automatic put(input int lane, input logic bad = 1'b0, input logic [7:0] disp = 8'h00,
                     input logic aligned = 1'b1, input logic clr = 1'b0);
    logic [63:0] d;
    d = {8{FILL_BYTE}};
    d[8*lane +: 8] = COMMA_BYTE;
    if (bad) d[8*((lane + 3) % 8) +: 8] = 8'h00;
    rx.rx_data_i = d;
    rx.rx_k_i = 8'd1 << lane;
    rx.rx_nit_i = 8'h00;
    rx.rx_disp_err_i = disp;
    rx.rx_aligned_i = aligned;
    clr_i = clr;
    @(posedge rx_clk);
    #1;
  endtask
  task automatic lock_seq(input int lane);
    for (int c = 1; c <= 18; c++) begin
      put(lane);
      if (c == 17) chk("lock_early", 32'(locked_o), 0);
      if (c == 18) chk("lock_at_18", 32'(locked_o), 1);
    end
    chk("lock_lane", 32'(comma_lane_o), 32'(lane));
  endtask
  task automatic relock(input int lane);
    put(0, 1'b0, 8'h00, 1'b0, 1'b1);
    put(0, 1'b0, 8'h00, 1'b0, 1'b1);
    lock_seq(lane);
  endtask
  initial begin
    tbl[0]  = '{1'b1, 1'b0, 16'd0,  1'b1};
    tbl[1]  = '{1'b1, 1'b1, 16'd1,  1'b1};
    tbl[2]  = '{1'b1, 1'b1, 16'd2,  1'b1};
    tbl[3]  = '{1'b0, 1'b1, 16'd3,  1'b1};
    tbl[4]  = '{1'b1, 1'b0, 16'd3,  1'b1};
    tbl[5]  = '{1'b1, 1'b1, 16'd4,  1'b1};
    tbl[6]  = '{1'b1, 1'b1, 16'd5,  1'b1};
    tbl[7]  = '{1'b0, 1'b1, 16'd6,  1'b1};
    tbl[8]  = '{1'b1, 1'b0, 16'd6,  1'b1};
    tbl[9]  = '{1'b1, 1'b1, 16'd7,  1'b1};
    tbl[10] = '{1'b1, 1'b1, 16'd8,  1'b1};
    tbl[11] = '{1'b1, 1'b1, 16'd9,  1'b1};
    tbl[12] = '{1'b0, 1'b1, 16'd10, 1'b0};
    tbl[13] = '{1'b0, 1'b0, 16'd10, 1'b0};
    rx.rx_data_i = '0;
    rx.rx_k_i = '0;
    rx.rx_nit_i = '0;
    rx.rx_disp_err_i = '0;
    rx.rx_aligned_i = 1'b0;
    repeat (3) @(posedge rx_clk);
    #1;
    chk("rst_locked", 32'(locked_o), 0);
    chk("rst_lane", 32'(comma_lane_o), 0);
    chk("rst_err", 32'(err_o), 0);
    chk("rst_err_cnt", 32'(err_cnt_o), 0);
    chk("rst_word_cnt", word_cnt_o, 0);
    rx_rstn_i = 1'b1;
    for (int c = 1; c <= 23; c++) begin
      put(0);
      if (c == 17) chk("a_lock_early", 32'(locked_o), 0);
      if (c == 18) chk("a_lock_at_18", 32'(locked_o), 1);
      if (c == 19) chk("a_word_cnt_1", word_cnt_o, 1);
      if (c == 23) chk("a_word_cnt_5", word_cnt_o, 5);
    end
    chk("a_lane", 32'(comma_lane_o), 0);
    chk("a_err_cnt", 32'(err_cnt_o), 0);
    for (int i = 0; i < 14; i++) begin
      put(0, tbl[i].bad);
      chk($sformatf("tbl%0d_err", i), 32'(err_o), 32'(tbl[i].exp_err));
      chk($sformatf("tbl%0d_cnt", i), 32'(err_cnt_o), 32'(tbl[i].exp_cnt));
      chk($sformatf("tbl%0d_lock", i), 32'(locked_o), 32'(tbl[i].exp_lock));
    end
    relock(0);
    put(0, 1'b0, 8'h10);
    put(0);
    chk("b_disp_err", 32'(err_o), 1);
    chk("b_disp_cnt", 32'(err_cnt_o), 1);
    put(0);
    chk("b_err_pulse", 32'(err_o), 0);
    chk("b_still_locked", 32'(locked_o), 1);
    put(0, 1'b0, 8'h00, 1'b0);
    put(0);
    chk("b_unaligned_lock", 32'(locked_o), 0);
    chk("b_unaligned_err", 32'(err_o), 0);
    chk("b_unaligned_cnt", 32'(err_cnt_o), 1);
    put(0, 1'b0, 8'h00, 1'b0);
    put(0, 1'b0, 8'h00, 1'b0);
    for (int c = 1; c <= 10; c++) put(5);
    chk("c_lane5", 32'(comma_lane_o), 5);
    chk("c_lane5_unlocked", 32'(locked_o), 0);
    for (int c = 1; c <= 19; c++) begin
      put(2);
      if (c == 1) chk("c_lane_held", 32'(comma_lane_o), 5);
      if (c == 18) chk("c_lock_early", 32'(locked_o), 0);
      if (c == 19) chk("c_lock", 32'(locked_o), 1);
    end
    chk("c_lane2", 32'(comma_lane_o), 2);
    force dut.err_cnt_o = 16'hFFFD;
    #1;
    release dut.err_cnt_o;
    put(2, 1'b1);
    put(2, 1'b1);
    put(2, 1'b1);
    chk("d_reach_ffff", 32'(err_cnt_o), 32'hFFFF);
    put(2, 1'b1, 8'h00, 1'b1, 1'b1);
    chk("d_sat_hold", 32'(err_cnt_o), 32'hFFFF);
    chk("d_sat_locked", 32'(locked_o), 1);
    put(2);
    chk("d_clr_wins", 32'(err_cnt_o), 0);
    chk("d_clr_err", 32'(err_o), 1);
    chk("d_unlock", 32'(locked_o), 0);
    relock(0);
    put(0);
    put(0);
    put(0);
    chk("e_word_cnt", word_cnt_o, 3);
    #2;
    rx_rstn_i = 1'b0;
    #1;
    chk("e_rst_locked", 32'(locked_o), 0);
    chk("e_rst_lane", 32'(comma_lane_o), 0);
    chk("e_rst_err", 32'(err_o), 0);
    chk("e_rst_err_cnt", 32'(err_cnt_o), 0);
    chk("e_rst_word_cnt", word_cnt_o, 0);
    @(posedge rx_clk);
    #1;
    rx_rstn_i = 1'b1;
    lock_seq(3);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/serdes_lb_checker.md
# serdes_lb_checker

Loopback pattern checker on the SERDES RX side, clocked by the recovered CDR clock (RX_CLK_O). It consumes the decoded 64-bit RX word with per-byte K/error flags and checks it against the loopback comma pattern: one K28.5 byte (0xBC, K=1) in one lane, 0x4A (K=0) in the other seven lanes. It finds the comma lane, locks after a run of good words, counts errors while locked and drops lock on a consecutive-error burst. Outputs drive the board status LEDs and the bring-up logic.

## Interface
- COMMA_BYTE, 8'hBC: expected K character (K28.5).
- FILL_BYTE, 8'h4A: expected data byte in non-comma lanes.
- LOCK_WORDS, 16: consecutive good words, same lane, required to enter LOCKED (2..255).
- UNLOCK_ERRS, 4: consecutive bad words in LOCKED that force HUNT (1..15).
- rx_clk  in  1  RX recovered clock; all logic on rising edge.
- rx_rstn_i  in  1  asynchronous active-low reset.
- rx_data_i  in  64  decoded RX word, lane n = bits [8n+7:8n].
- rx_k_i  in  8  per-lane char-is-K.
- rx_nit_i  in  8  per-lane not-in-table.
- rx_disp_err_i  in  8  per-lane disparity error.
- rx_aligned_i  in  1  byte-is-aligned from the SERDES.
- clr_i  in  1  synchronous clear of the counters.
- locked_o  out  1  state == LOCKED.
- comma_lane_o  out  3  captured comma lane.
- err_o  out  1  one-cycle pulse per bad word while LOCKED.
- err_cnt_o  out  16  saturating count of bad words while LOCKED.
- word_cnt_o  out  32  saturating count of words checked while LOCKED.

## Operation
- Stage 1 registers all inputs. Stage 2 classifies the registered word.
- Good word with lane L: rx_k == (1<<L); byte L == COMMA_BYTE; the other seven bytes == FILL_BYTE; rx_nit == 0; rx_disp_err == 0. Any other word is bad. L is unique by construction.
- FSM states: HUNT, VERIFY, LOCKED. Reset state is HUNT.
- HUNT: on a good word, capture L into comma_lane, set good_cnt=1 and go to VERIFY. Otherwise stay.
- VERIFY: a good word in the same lane increments good_cnt. When good_cnt reaches LOCK_WORDS, go to LOCKED with bad_cnt=0. A bad word, or a good word in a different lane, goes to HUNT with good_cnt=0. No errors are counted in VERIFY.
- LOCKED, every word: word_cnt++.
  - Bad word, or good word in a different lane: err_o=1, err_cnt++, bad_cnt++. When bad_cnt reaches UNLOCK_ERRS, go to HUNT.
  - Good word in the same lane: bad_cnt=0.
- Registered rx_aligned low in any state: go to HUNT next cycle, good_cnt=bad_cnt=0. That word is not counted and raises no err_o.
- Both counters saturate at all-ones and hold.
- clr_i zeroes err_cnt and word_cnt. Clear wins over a same-cycle increment. clr_i does not change the FSM or comma_lane.
- comma_lane holds its value across HUNT and updates only on the HUNT→VERIFY transition.

## Timing
- Reset values: locked_o=0, comma_lane_o=0, err_o=0, err_cnt_o=0, word_cnt_o=0, FSM=HUNT.
- Latency from input word to its err_o pulse, counter update and state change: 2 cycles. Outputs are registered.
- First LOCKED cycle: locked_o rises 2+LOCK_WORDS cycles after the first good word enters.
- Unlock: locked_o falls on the same edge that registers the UNLOCK_ERRS-th consecutive bad word's err_o.
- Reset asserted mid-operation returns every register to its reset value immediately. The first word after deassertion is the first one classified.

## Structure
- Package serdes_lb_pkg holds: FSM state enum (HUNT/VERIFY/LOCKED), K28.5 and fill byte constants, and the lane-count constant (8).
- One sub-module, serdes_lb_word_cmp: combinational classifier producing good and lane[2:0] from the registered word. It is reusable by the TX-side self-check.

## Test plan
- Clean pattern, comma in lane 0 (data 64'h4A4A4A4A_4A4A4ABC, k=8'h01), continuous → locked_o=1 exactly 18 cycles after the first word; comma_lane_o=0; err_cnt_o stays 0; word_cnt_o increments by 1 per cycle.
- Lane 5 (64'h4A4ABC4A_4A4A4A4A, k=8'h20) for 10 words, then lane 2 → returns to HUNT, recaptures lane 2, locks 16 words later; comma_lane_o=2.
- Locked, then 3 bad words (one byte 8'h00), then good, then 3 bad → err_cnt_o=6, six err_o pulses, stays locked. Then 4 consecutive bad → locked_o=0 and err_cnt_o=10.
- Locked, rx_disp_err_i=8'h10 for one word → single err_o pulse, err_cnt_o=1. Then rx_aligned_i=0 for one cycle → HUNT, err_cnt_o unchanged.
- Preload err_cnt_o to 16'hFFFF via sustained errors (force model) → holds at FFFF. clr_i together with a bad word → err_cnt_o=0.
- rx_rstn_i low for one cycle while locked → all outputs 0 asynchronously. Lock reacquired 18 cycles after release with clean input.
